hub75_rx: RTL and testbench

- Receive side of the HUB75 panel interface: samples the Clk/Lat/OE/A–E/RGB pins a matrix driver produces.
- Reconstructs each shifted line into a parallel word, tagged with its row address, plus column-count check and OE on-time measurement.
- Used for loopback verification of our matrix drivers on the Tang Nano 9K and as the input stage of a panel-chaining/sniffer path.
- Runs entirely in the 27 MHz system clock domain; HUB75 pins are treated as asynchronous.

---
 rtl/hub75_pkg.sv | 23 ++
 rtl/hub75_rx_if.sv | 41 ++++
 rtl/hub75_sync_edge.sv | 64 ++++++
 rtl/hub75_rx.sv | 154 +++++++++++++++
 tb/tb_hub75_rx.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hub75_pkg.sv
// hub75_pkg
// Shared HUB75 constants used by both the driver and the receive side.
//   ADDR_BITS  : width of the row address bus {E,D,C,B,A}
//   RGB_BITS   : width of the pixel bus {B2,B1,G2,G1,R2,R1}
//   *_IDX      : bit position of each colour pin inside the pixel bus
//   sat_inc8   : 8-bit increment that sticks at 255
package hub75_pkg;

    localparam int ADDR_BITS = 5;
    localparam int RGB_BITS  = 6;

    localparam int R1_IDX = 0;
    localparam int R2_IDX = 1;
    localparam int G1_IDX = 2;
    localparam int G2_IDX = 3;
    localparam int B1_IDX = 4;
    localparam int B2_IDX = 5;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/hub75_rx_if.sv
// hub75_rx_if
// Bundles the HUB75 pins and the reconstructed-line / OE-measurement results.
//   master : drives the panel pins, observes the results (driver or bench)
//   slave  : samples the panel pins, produces the results (hub75_rx)
interface hub75_rx_if #(
    parameter int COLS        = 32,
    parameter int OE_CNT_BITS = 16
);

    // Panel pins
    logic                            h75_clk;
    logic                            h75_lat;
    logic                            h75_oe;
    logic [hub75_pkg::ADDR_BITS-1:0] h75_addr;
    logic [hub75_pkg::RGB_BITS-1:0]  h75_rgb;

    // Reconstructed line
    logic                            line_valid;
    logic [hub75_pkg::ADDR_BITS-1:0] line_addr;
    logic [6*COLS-1:0]               line_data;
    logic [7:0]                      line_cols;
    logic                            col_err;
    logic                            frame_start;

    // OE on-time measurement
    logic [OE_CNT_BITS-1:0]          oe_cycles;
    logic                            oe_valid;

    modport master (
        output h75_clk, h75_lat, h75_oe, h75_addr, h75_rgb,
        input  line_valid, line_addr, line_data, line_cols, col_err, frame_start,
        input  oe_cycles, oe_valid
    );

    modport slave (
        input  h75_clk, h75_lat, h75_oe, h75_addr, h75_rgb,
        output line_valid, line_addr, line_data, line_cols, col_err, frame_start,
        output oe_cycles, oe_valid
    );

endinterface

// File: rtl/hub75_sync_edge.sv
// hub75_sync_edge
// Multi-flop synchronizer for asynchronous pins with optional rising-edge detect.
//   clk, rst : system clock, asynchronous active-high reset
//   din      : asynchronous input pins
//   level    : synchronized level (last synchronizer stage)
//   rise     : one-cycle pulse per bit on a synchronized 0->1 transition
//              (constant 0 when EDGE == 0)
// RST_VAL lets idle-high pins (OE) come out of reset without a false edge.
module hub75_sync_edge #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter bit               EDGE    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign level = stage_q[DEPTH-1];

    generate
        if (EDGE) begin : g_edge
            logic [WIDTH-1:0] dly_q;
            logic [WIDTH-1:0] dly_d;

            always_comb dly_d = level;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) dly_q <= RST_VAL;
                else     dly_q <= dly_d;
            end

            assign rise = level & ~dly_q;
        end else begin : g_no_edge
            assign rise = '0;
        end
    endgenerate

endmodule

// File: rtl/hub75_rx.sv
// hub75_rx
// HUB75 receive side: samples the panel pins in the system clock domain and
// rebuilds each shifted line into a parallel word tagged with its row address,
// counts columns per line and measures how long OE was low per display window.
//   clk, rst          : system clock (27 MHz), asynchronous active-high reset
//   bus.h75_*         : HUB75 panel pins (asynchronous)
//   bus.line_valid    : one-cycle pulse, line_* updated this cycle
//   bus.line_addr     : row address captured at latch
//   bus.line_data     : column c at bits [6c+5:6c]
//   bus.line_cols     : shift edges seen for the line (saturates at 255)
//   bus.col_err       : line_cols != COLS
//   bus.frame_start   : pulse with line_valid when line_addr == 0
//   bus.oe_cycles     : clk cycles OE was low in the last window
//   bus.oe_valid      : one-cycle pulse, oe_cycles updated this cycle
module hub75_rx
    import hub75_pkg::*;
#(
    parameter int COLS        = 32,
    parameter int SYNC_STAGES = 2,
    parameter int OE_CNT_BITS = 16
) (
    input  logic     clk,
    input  logic     rst,
    hub75_rx_if.slave bus
);

    localparam int         LW       = RGB_BITS * COLS;
    localparam logic [7:0] COLS_CNT = 8'(COLS);

    // ---------------- synchronizers ----------------
    logic                          clk_lvl_unused, clk_rise;
    logic                          lat_lvl_unused, lat_rise;
    logic                          oe_sync, oe_rise;
    logic [ADDR_BITS+RGB_BITS-1:0] data_sync, data_rise_unused;
    logic [ADDR_BITS-1:0]          addr_sync;
    logic [RGB_BITS-1:0]           rgb_sync;

    hub75_sync_edge #(.WIDTH(1), .DEPTH(SYNC_STAGES), .RST_VAL(1'b0), .EDGE(1'b1)) u_sync_clk (
        .clk(clk), .rst(rst), .din(bus.h75_clk), .level(clk_lvl_unused), .rise(clk_rise)
    );

    hub75_sync_edge #(.WIDTH(1), .DEPTH(SYNC_STAGES), .RST_VAL(1'b0), .EDGE(1'b1)) u_sync_lat (
        .clk(clk), .rst(rst), .din(bus.h75_lat), .level(lat_lvl_unused), .rise(lat_rise)
    );

    // OE idles high (blanked), so its chain resets to 1 to avoid a false rise.
    hub75_sync_edge #(.WIDTH(1), .DEPTH(SYNC_STAGES), .RST_VAL(1'b1), .EDGE(1'b1)) u_sync_oe (
        .clk(clk), .rst(rst), .din(bus.h75_oe), .level(oe_sync), .rise(oe_rise)
    );

    hub75_sync_edge #(
        .WIDTH(ADDR_BITS + RGB_BITS), .DEPTH(SYNC_STAGES), .RST_VAL('0), .EDGE(1'b0)
    ) u_sync_data (
        .clk(clk), .rst(rst), .din({bus.h75_addr, bus.h75_rgb}),
        .level(data_sync), .rise(data_rise_unused)
    );

    assign addr_sync = data_sync[ADDR_BITS+RGB_BITS-1:RGB_BITS];
    assign rgb_sync  = data_sync[RGB_BITS-1:0];

    // ---------------- state ----------------
    logic [LW-1:0]          shreg_q, shreg_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   line_valid_q, line_valid_d;
    logic [ADDR_BITS-1:0]   line_addr_q, line_addr_d;
    logic [LW-1:0]          line_data_q, line_data_d;
    logic [7:0]             line_cols_q, line_cols_d;
    logic                   col_err_q, col_err_d;
    logic                   frame_start_q, frame_start_d;
    logic [OE_CNT_BITS-1:0] oe_cnt_q, oe_cnt_d;
    logic [OE_CNT_BITS-1:0] oe_cycles_q, oe_cycles_d;
    logic                   oe_valid_q, oe_valid_d;

    always_comb begin
        shreg_d       = shreg_q;
        cnt_d         = cnt_q;
        line_valid_d  = 1'b0;
        line_addr_d   = line_addr_q;
        line_data_d   = line_data_q;
        line_cols_d   = line_cols_q;
        col_err_d     = col_err_q;
        frame_start_d = 1'b0;

        // New pixels enter at the top so the first one ends up in column 0.
        if (clk_rise) begin
            shreg_d = {rgb_sync, shreg_q[LW-1:RGB_BITS]};
            cnt_d   = sat_inc8(cnt_q);
        end

        // Capture uses the post-shift values so a shift coinciding with the
        // latch is part of the line.
        if (lat_rise) begin
            line_valid_d  = 1'b1;
            line_data_d   = shreg_d;
            line_addr_d   = addr_sync;
            line_cols_d   = cnt_d;
            col_err_d     = (cnt_d != COLS_CNT);
            frame_start_d = (addr_sync == '0);
            cnt_d         = '0;
        end
    end

    always_comb begin
        oe_cnt_d    = oe_cnt_q;
        oe_cycles_d = oe_cycles_q;
        oe_valid_d  = 1'b0;

        if (oe_rise) begin
            oe_cycles_d = oe_cnt_q;
            oe_valid_d  = 1'b1;
            oe_cnt_d    = '0;
        end else if (!oe_sync && (oe_cnt_q != '1)) begin
            oe_cnt_d = oe_cnt_q + OE_CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q       <= '0;
            cnt_q         <= '0;
            line_valid_q  <= 1'b0;
            line_addr_q   <= '0;
            line_data_q   <= '0;
            line_cols_q   <= '0;
            col_err_q     <= 1'b0;
            frame_start_q <= 1'b0;
            oe_cnt_q      <= '0;
            oe_cycles_q   <= '0;
            oe_valid_q    <= 1'b0;
        end else begin
            shreg_q       <= shreg_d;
            cnt_q         <= cnt_d;
            line_valid_q  <= line_valid_d;
            line_addr_q   <= line_addr_d;
            line_data_q   <= line_data_d;
            line_cols_q   <= line_cols_d;
            col_err_q     <= col_err_d;
            frame_start_q <= frame_start_d;
            oe_cnt_q      <= oe_cnt_d;
            oe_cycles_q   <= oe_cycles_d;
            oe_valid_q    <= oe_valid_d;
        end
    end

    assign bus.line_valid  = line_valid_q;
    assign bus.line_addr   = line_addr_q;
    assign bus.line_data   = line_data_q;
    assign bus.line_cols   = line_cols_q;
    assign bus.col_err     = col_err_q;
    assign bus.frame_start = frame_start_q;
    assign bus.oe_cycles   = oe_cycles_q;
    assign bus.oe_valid    = oe_valid_q;

endmodule

// File: tb/tb_hub75_rx.sv
`timescale 1ns/1ps
module tb_hub75_rx;

    localparam int COLS = 32;
    localparam int LW   = 6 * COLS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #18 clk = ~clk;

    hub75_rx_if #(.COLS(COLS), .OE_CNT_BITS(16)) bus ();

    hub75_rx #(.COLS(COLS), .SYNC_STAGES(2), .OE_CNT_BITS(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [LW-1:0] data;
        logic [4:0]    addr;
        logic [7:0]    cols;
        logic          err;
        logic          fs;
    } line_exp_t;

    typedef struct {
        int val;
        int tol;
    } oe_exp_t;

    line_exp_t line_q[$];
    oe_exp_t   oe_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model of the receiver's shift register and column count
    logic [LW-1:0] m_sh  = '0;
    int            m_cnt = 0;

    // ---------------- scoreboard monitor ----------------
    line_exp_t me;
    oe_exp_t   oe_e;
    int        oe_diff;

    always @(negedge clk) begin
        if (bus.line_valid) begin
            if (line_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_line got addr=%0d cols=%0d exp no pulse", bus.line_addr, bus.line_cols);
            end else begin
                me = line_q.pop_front();
                $display("line addr=%0d cols=%0d err=%0d fs=%0d", bus.line_addr, bus.line_cols, bus.col_err, bus.frame_start);
                total++;
                if (bus.line_addr !== me.addr) begin
                    bad++; $display("FAIL line_addr got=%0d exp=%0d", bus.line_addr, me.addr);
                end
                total++;
                if (bus.line_data !== me.data) begin
                    bad++; $display("FAIL line_data got=%h exp=%h", bus.line_data, me.data);
                end
                total++;
                if (bus.line_cols !== me.cols) begin
                    bad++; $display("FAIL line_cols got=%0d exp=%0d", bus.line_cols, me.cols);
                end
                total++;
                if (bus.col_err !== me.err) begin
                    bad++; $display("FAIL col_err got=%0d exp=%0d", bus.col_err, me.err);
                end
                total++;
                if (bus.frame_start !== me.fs) begin
                    bad++; $display("FAIL frame_start got=%0d exp=%0d", bus.frame_start, me.fs);
                end
            end
        end
        if (bus.oe_valid) begin
            if (oe_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_oe got oe_cycles=%0d exp no pulse", bus.oe_cycles);
            end else begin
                oe_e = oe_q.pop_front();
                $display("oe cycles=%0d", bus.oe_cycles);
                oe_diff = int'(bus.oe_cycles) - oe_e.val;
                if (oe_diff < 0) oe_diff = -oe_diff;
                total++;
                if (oe_diff > oe_e.tol) begin
                    bad++; $display("FAIL oe_cycles got=%0d exp=%0d tol=%0d", bus.oe_cycles, oe_e.val, oe_e.tol);
                end
            end
        end
    end

    // ---------------- pin drivers / model ----------------
    task automatic shift_px(input logic [5:0] px);
        @(negedge clk);
        bus.h75_rgb = px;
        repeat (3) @(negedge clk);
        bus.h75_clk = 1'b1;
        m_sh  = {px, m_sh[LW-1:6]};
        m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
        repeat (4) @(negedge clk);
        bus.h75_clk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic push_line(input logic [4:0] addr);
        line_exp_t e;
        e.data = m_sh;
        e.addr = addr;
        e.cols = 8'(m_cnt);
        e.err  = (m_cnt != COLS);
        e.fs   = (addr == 5'd0);
        line_q.push_back(e);
        m_cnt = 0;
    endtask

    task automatic do_latch(input logic [4:0] addr);
        @(negedge clk);
        bus.h75_addr = addr;
        repeat (3) @(negedge clk);
        push_line(addr);
        bus.h75_lat = 1'b1;
        repeat (4) @(negedge clk);
        bus.h75_lat = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic shift_and_latch(input logic [5:0] px, input logic [4:0] addr);
        @(negedge clk);
        bus.h75_rgb  = px;
        bus.h75_addr = addr;
        repeat (3) @(negedge clk);
        m_sh  = {px, m_sh[LW-1:6]};
        m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
        push_line(addr);
        bus.h75_clk = 1'b1;
        bus.h75_lat = 1'b1;
        repeat (4) @(negedge clk);
        bus.h75_clk = 1'b0;
        bus.h75_lat = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic oe_low(input int n, input int tol);
        oe_exp_t e;
        @(negedge clk);
        bus.h75_oe = 1'b0;
        repeat (n) @(negedge clk);
        e.val = (n > 65535) ? 65535 : n;
        e.tol = tol;
        oe_q.push_back(e);
        bus.h75_oe = 1'b1;
    endtask

    // Waits (bounded) for the scoreboard queues to drain
    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (line_q.size() == 0 && oe_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.h75_clk = 1'b0; bus.h75_lat = 1'b0; bus.h75_oe = 1'b1;
        bus.h75_addr = '0; bus.h75_rgb = '0;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        total++; if (bus.line_valid !== 1'b0)  begin bad++; $display("FAIL rst_line_valid got=%b exp=0", bus.line_valid); end
        total++; if (bus.line_addr !== 5'd0)   begin bad++; $display("FAIL rst_line_addr got=%0d exp=0", bus.line_addr); end
        total++; if (bus.line_data !== '0)     begin bad++; $display("FAIL rst_line_data got=%h exp=0", bus.line_data); end
        total++; if (bus.line_cols !== 8'd0)   begin bad++; $display("FAIL rst_line_cols got=%0d exp=0", bus.line_cols); end
        total++; if (bus.col_err !== 1'b0)     begin bad++; $display("FAIL rst_col_err got=%b exp=0", bus.col_err); end
        total++; if (bus.frame_start !== 1'b0) begin bad++; $display("FAIL rst_frame_start got=%b exp=0", bus.frame_start); end
        total++; if (bus.oe_cycles !== 16'd0)  begin bad++; $display("FAIL rst_oe_cycles got=%0d exp=0", bus.oe_cycles); end
        total++; if (bus.oe_valid !== 1'b0)    begin bad++; $display("FAIL rst_oe_valid got=%b exp=0", bus.oe_valid); end
        rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_basic_line();
        bit ok;
        for (int c = 0; c < COLS; c++) shift_px(6'(c));
        do_latch(5'd7);
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_timeout got pending=%0d exp 0", line_q.size()); end
    endtask

    task automatic test_frame_start();
        bit ok;
        for (int c = 0; c < COLS; c++) shift_px(6'(63 - c));
        do_latch(5'd0);
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL frame_timeout got pending=%0d exp 0", line_q.size()); end
    endtask

    task automatic test_short_long();
        bit ok;
        for (int c = 0; c < COLS - 1; c++) shift_px(6'(c + 20));
        do_latch(5'd3);
        for (int c = 0; c < COLS + 1; c++) shift_px(6'(c + 10));
        do_latch(5'd4);
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL shortlong_timeout got pending=%0d exp 0", line_q.size()); end
        total++;
        if (bus.line_data[5:0] !== 6'd11) begin
            bad++; $display("FAIL long_col0 got=%0d exp=11", bus.line_data[5:0]);
        end
    endtask

    task automatic test_oe();
        bit ok;
        oe_low(1000, 1);
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL oe_timeout got pending=%0d exp 0", oe_q.size()); end
        oe_low(70000, 0);
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL oe_sat_timeout got pending=%0d exp 0", oe_q.size()); end
    endtask

    task automatic test_simultaneous();
        bit ok;
        for (int c = 0; c < COLS - 1; c++) shift_px(6'(c + 1));
        shift_and_latch(6'd42, 5'd9);
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL simul_timeout got pending=%0d exp 0", line_q.size()); end
        total++;
        if (bus.line_data[LW-1:LW-6] !== 6'd42) begin
            bad++; $display("FAIL simul_last_px got=%0d exp=42", bus.line_data[LW-1:LW-6]);
        end
    endtask

    task automatic test_reset_midline();
        bit ok;
        for (int c = 0; c < 10; c++) shift_px(6'(c + 30));
        @(negedge clk);
        rst = 1'b1;
        m_sh  = '0;
        m_cnt = 0;
        repeat (3) @(negedge clk);
        total++; if (bus.line_cols !== 8'd0) begin bad++; $display("FAIL midrst_line_cols got=%0d exp=0", bus.line_cols); end
        total++; if (bus.line_valid !== 1'b0) begin bad++; $display("FAIL midrst_line_valid got=%b exp=0", bus.line_valid); end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        for (int c = 0; c < COLS; c++) shift_px(6'(c ^ 6'h15));
        do_latch(5'd5);
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL midrst_timeout got pending=%0d exp 0", line_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic_line();
        test_frame_start();
        test_short_long();
        test_oe();
        test_simultaneous();
        test_reset_midline();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3400000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
